// File: rtl/i2c_mem_slave.sv
// i2c slave with an internal memory addressed by the first byte of each frame.
// Optional feature macro: I2C_SLAVE_AUTOINC_EN (multi-byte bursts with address auto-increment).
module i2c_mem_slave #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic SCL,
  input  logic SDA_IN,
  output logic SDA_OUT,
  output logic SDA_OE,
  output logic ack_n,
  output logic busy,
  output logic wr_done
);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ?
                      ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0] ABITS = CW'(ADDR_WIDTH + 1);
  localparam logic [CW-1:0] DBITS = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE,
    WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_e;

  logic [1:0]            scl_sync_q;
  logic [1:0]            sda_sync_q;
  logic                  scl_prev_q;
  logic                  sda_prev_q;
  state_e                state_q;
  logic [SW-2:0]         shift_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic                  mack_q;
  logic                  sda_out_q;
  logic                  sda_oe_q;
  logic                  ack_n_q;
  logic                  busy_q;
  logic                  wr_done_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  scl_s;
  logic                  sda_s;
  logic                  scl_rise;
  logic                  scl_fall;
  logic                  start_c;
  logic                  stop_c;
  logic                  mem_we_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic [SW-2:0]         shift_d;

  always_comb begin
    scl_s     = scl_sync_q[1];
    sda_s     = sda_sync_q[1];
    scl_rise  = scl_s & ~scl_prev_q;
    scl_fall  = ~scl_s & scl_prev_q;
    start_c   = scl_s & sda_prev_q & ~sda_s;
    stop_c    = scl_s & ~sda_prev_q & sda_s;
    shift_d   = {shift_q[SW-3:0], sda_s};
    wdata_d   = {shift_q[DATA_WIDTH-2:0], sda_s};
    rd_word_d = mem_q[addr_q];
    mem_we_d  = (state_q == WRITE) && scl_rise &&
                !start_c && !stop_c &&
                (cnt_q == DBITS - ONE);
  end

  // Memory contents survive reset; only complete bytes are written.
  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[addr_q] <= wdata_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_out_q  <= 1'b1;
      sda_oe_q   <= 1'b0;
      ack_n_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA_IN};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      wr_done_q  <= mem_we_d;
      if (stop_c) begin
        state_q   <= IDLE;
        sda_out_q <= 1'b1;
        sda_oe_q  <= 1'b0;
        ack_n_q   <= 1'b1;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
      end else if (start_c) begin
        state_q   <= ADDR;
        sda_out_q <= 1'b1;
        sda_oe_q  <= 1'b0;
        ack_n_q   <= 1'b1;
        busy_q    <= 1'b1;
        cnt_q     <= '0;
        shift_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise && cnt_q != ABITS) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + ONE;
              if (cnt_q == ABITS - ONE) begin
                addr_q <= shift_q[ADDR_WIDTH-1:0];
                rw_q   <= sda_s;
              end
            end else if (scl_fall && cnt_q == ABITS) begin
              state_q   <= ADDR_ACK;
              sda_out_q <= 1'b0;
              sda_oe_q  <= 1'b1;
              ack_n_q   <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              ack_n_q <= 1'b1;
              shift_q <= '0;
              if (rw_q) begin
                state_q   <= WRITE;
                sda_out_q <= 1'b1;
                sda_oe_q  <= 1'b0;
                cnt_q     <= '0;
              end else begin
                state_q   <= READ;
                sda_out_q <= rd_word_d[DATA_WIDTH-1];
                sda_oe_q  <= 1'b1;
                tx_q      <= {rd_word_d[DATA_WIDTH-2:0], 1'b0};
                cnt_q     <= ONE;
              end
            end
          end
          WRITE: begin
            if (scl_rise && cnt_q != DBITS) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + ONE;
            end else if (scl_fall && cnt_q == DBITS) begin
              state_q   <= WRITE_ACK;
              sda_out_q <= 1'b0;
              sda_oe_q  <= 1'b1;
              ack_n_q   <= 1'b0;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_out_q <= 1'b1;
              sda_oe_q  <= 1'b0;
              ack_n_q   <= 1'b1;
              cnt_q     <= '0;
              if (AutoInc) begin
                state_q <= WRITE;
                addr_q  <= addr_q + ADDR_WIDTH'(1);
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          READ: begin
            if (scl_fall) begin
              if (cnt_q == DBITS) begin
                state_q   <= READ_ACK;
                sda_out_q <= 1'b1;
                sda_oe_q  <= 1'b0;
                cnt_q     <= '0;
              end else begin
                sda_out_q <= tx_q[DATA_WIDTH-1];
                tx_q      <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                cnt_q     <= cnt_q + ONE;
              end
            end
          end
          READ_ACK: begin
            // Address advances on the master's ACK so the next word is ready at SCL fall.
            if (scl_rise) begin
              mack_q <= ~sda_s;
              if (AutoInc && !sda_s) addr_q <= addr_q + ADDR_WIDTH'(1);
            end else if (scl_fall) begin
              if (AutoInc && mack_q) begin
                state_q   <= READ;
                sda_out_q <= rd_word_d[DATA_WIDTH-1];
                sda_oe_q  <= 1'b1;
                tx_q      <= {rd_word_d[DATA_WIDTH-2:0], 1'b0};
                cnt_q     <= ONE;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign SDA_OUT = sda_out_q;
  assign SDA_OE  = sda_oe_q;
  assign ack_n   = ack_n_q;
  assign busy    = busy_q;
  assign wr_done = wr_done_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed and randomized bench for i2c_mem_slave with a behavioural memory model.
// Honours I2C_SLAVE_AUTOINC_EN to predict burst behaviour.
module tb_i2c_mem_slave;

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int H = 12;

  logic clk = 1'b0;
  logic reset;
  logic scl_m;
  logic sda_m;
  logic sda_out;
  logic sda_oe;
  logic ack_n;
  logic busy;
  logic wr_done;
  logic sda_bus;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  logic [7:0] ref_mem [128];

  assign sda_bus = sda_m & (sda_oe ? sda_out : 1'b1);

  i2c_mem_slave dut (
    .clk    (clk),
    .reset  (reset),
    .SCL    (scl_m),
    .SDA_IN (sda_bus),
    .SDA_OUT(sda_out),
    .SDA_OE (sda_oe),
    .ack_n  (ack_n),
    .busy   (busy),
    .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_done === 1'b1) wr_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(6);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(6);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(6);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(6);
    scl_m = 1'b1; tick(H);
    scl_m = 1'b0; tick(6);
  endtask

  task automatic get_bit(output logic b, output logic oe,
                         output logic an);
    sda_m = 1'b1; tick(6);
    scl_m = 1'b1; tick(6);
    b = sda_bus; oe = sda_oe; an = ack_n;
    tick(6);
    scl_m = 1'b0; tick(6);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ab,
                           output logic an);
    logic oe;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ab, oe, an);
  endtask

  task automatic recv_byte(output logic [7:0] d, output logic oe_and,
                           output logic oe_or);
    logic b, oe, an;
    oe_and = 1'b1; oe_or = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b, oe, an);
      d[i] = b;
      oe_and &= oe;
      oe_or |= oe;
    end
  endtask

  // Model: without auto-increment only the first data byte of a frame lands.
  task automatic do_write(input logic [6:0] a, input int n,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input string tag);
    int base, acc;
    logic ab, an;
    logic [7:0] d;
    base = wr_cnt; acc = 0;
    i2c_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    send_byte({a, 1'b1}, ab, an);
    chk({tag, "_aack"}, 32'(ab), 32'd0);
    chk({tag, "_ackn"}, 32'(an), 32'd0);
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      send_byte(d, ab, an);
      if (AUTOINC || k == 0) begin
        ref_mem[7'(a + 7'(k))] = d;
        acc++;
        chk({tag, "_dack"}, 32'(ab), 32'd0);
      end else begin
        chk({tag, "_dnack"}, 32'(ab), 32'd1);
      end
    end
    i2c_stop();
    chk({tag, "_wrdone"}, 32'(wr_cnt - base), 32'(acc));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [6:0] a, input int n,
                         input string tag);
    logic ab, an, oa, oo;
    logic [7:0] d;
    i2c_start();
    send_byte({a, 1'b0}, ab, an);
    chk({tag, "_aack"}, 32'(ab), 32'd0);
    chk({tag, "_ackn"}, 32'(an), 32'd0);
    for (int k = 0; k < n; k++) begin
      recv_byte(d, oa, oo);
      if (AUTOINC || k == 0) begin
        chk({tag, "_data"}, 32'(d), 32'(ref_mem[7'(a + 7'(k))]));
        chk({tag, "_oe"}, 32'(oa), 32'd1);
      end else begin
        chk({tag, "_rel_data"}, 32'(d), 32'hFF);
        chk({tag, "_rel_oe"}, 32'(oo), 32'd0);
      end
      put_bit(k == n - 1);
    end
    chk({tag, "_oe_after"}, 32'(sda_oe), 32'd0);
    i2c_stop();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic ab, an, oe, b;
    logic [6:0] ra [4];
    logic [7:0] rd [4];
    logic [7:0] d;
    int base;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_out", 32'(sda_out), 32'd1);
    chk("rst_ackn", 32'(ack_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrdone", 32'(wr_done), 32'd0);
    reset = 1'b0;
    tick(6);
    chk("post_rst_busy", 32'(busy), 32'd0);

    do_write(7'h03, 1, 8'h02, 8'h00, "w03");
    do_read(7'h03, 1, "r03");

    for (int i = 0; i < 4; i++) begin
      ra[i] = 7'($urandom_range(32, 63));
      rd[i] = 8'($urandom);
      do_write(ra[i], 1, rd[i], 8'h00, "rnd_w");
    end
    for (int i = 0; i < 4; i++) do_read(ra[i], 1, "rnd_r");

    do_write(7'h51, 1, 8'h77, 8'h00, "pre51");
    do_write(7'h50, 2, 8'h11, 8'h22, "burst_w");
    do_read(7'h50, 2, "burst_r");
    do_read(7'h51, 1, "r51");

    do_write(7'h7F, 2, 8'hA5, 8'h5A, "wrap_w");
    do_read(7'h7F, 2, "wrap_r");

    // Stop after a partial data byte must not commit it.
    do_write(7'h10, 1, 8'h3C, 8'h00, "pre10");
    base = wr_cnt;
    i2c_start();
    send_byte({7'h10, 1'b1}, ab, an);
    chk("part_aack", 32'(ab), 32'd0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    chk("part_wrdone", 32'(wr_cnt - base), 32'd0);
    chk("part_idle", 32'(busy), 32'd0);
    do_read(7'h10, 1, "part_r");

    // Repeated start while the slave drives a '1' read bit.
    i2c_start();
    send_byte({7'h03, 1'b0}, ab, an);
    chk("rs_aack", 32'(ab), 32'd0);
    d = 8'h00;
    for (int i = 7; i >= 2; i--) begin
      get_bit(b, oe, an);
      d[i] = b;
    end
    chk("rs_bits", 32'(d[7:2]), 32'(ref_mem[3][7:2]));
    chk("rs_drive", 32'(sda_oe), 32'd1);
    i2c_start();
    chk("rs_release", 32'(sda_oe), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    base = wr_cnt;
    send_byte({7'h04, 1'b1}, ab, an);
    chk("rs_waack", 32'(ab), 32'd0);
    send_byte(8'hFF, ab, an);
    chk("rs_wdack", 32'(ab), 32'd0);
    ref_mem[4] = 8'hFF;
    i2c_stop();
    chk("rs_wrdone", 32'(wr_cnt - base), 32'd1);
    do_read(7'h04, 1, "rs_r");

    // Reset while the address ACK is on the bus.
    do_write(7'h05, 1, 8'h66, 8'h00, "pre05");
    base = wr_cnt;
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 0 ? 1'b1 : (i == 1 || i == 3));
    chk("ra_drive", 32'(sda_oe), 32'd1);
    chk("ra_ackn_low", 32'(ack_n), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("ra_oe", 32'(sda_oe), 32'd0);
    chk("ra_ackn", 32'(ack_n), 32'd1);
    chk("ra_out", 32'(sda_out), 32'd1);
    chk("ra_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    get_bit(ab, oe, an);
    chk("ra_noack", 32'(ab), 32'd1);
    send_byte(8'h99, ab, an);
    chk("ra_ignored", 32'(ab), 32'd1);
    chk("ra_idle", 32'(busy), 32'd0);
    i2c_stop();
    chk("ra_wrdone", 32'(wr_cnt - base), 32'd0);
    do_read(7'h05, 1, "ra_r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
